// File: rtl/motion_nios_debug_cmd_dispatch.sv
// motion_nios_debug_cmd_dispatch
// Sysclk-side dispatcher for virtual-JTAG debug-slave commands. The TCK-domain
// update strobes (vs_uir / vs_udr) are synchronised and edge-detected. Each
// update-DR captures {latched IR, shift register} into a small command FIFO.
// Commands are issued under a cmd_ready handshake as a jdo word plus a one-hot
// take_action / take_no_action pulse on the channel selected by the IR.
// Optional feature: define MOTION_DBG_CMD_COUNT_EN to enable the cmd_count
// dispatch counter. When it is undefined, cmd_count is tied to zero.
module motion_nios_debug_cmd_dispatch #(
    parameter int IR_WIDTH    = 2,
    parameter int DATA_WIDTH  = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACT_BIT     = 34
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [IR_WIDTH-1:0]        ir_in,
    input  logic [DATA_WIDTH-1:0]      sr,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    input  logic                       cmd_ready,
    input  logic                       ovf_clr,
    output logic [DATA_WIDTH-1:0]      jdo,
    output logic [IR_WIDTH-1:0]        cmd_ir,
    output logic [(2**IR_WIDTH)-1:0]   take_action,
    output logic [(2**IR_WIDTH)-1:0]   take_no_action,
    output logic                       fifo_empty,
    output logic                       overflow,
    output logic [15:0]                cmd_count
);

    localparam int NUM_CH = 2**IR_WIDTH;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int EW     = IR_WIDTH + DATA_WIDTH;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Synchroniser chains and edge-detect history
    logic [SYNC_STAGES-1:0] uir_sync_p0;
    logic [SYNC_STAGES-1:0] udr_sync_p0;
    logic                   uir_prev_p1;
    logic                   udr_prev_p1;
    logic                   uir_rise_p1;
    logic                   udr_rise_p1;
    logic [IR_WIDTH-1:0]    ir_latched;

    // Command FIFO
    logic [EW-1:0]          fifo_mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic                   fifo_full_w;
    logic                   fifo_empty_w;
    logic                   push_vld_p1;
    logic                   drop_p1;
    logic                   rd_vld_p1;
    logic [EW-1:0]          rd_entry;
    logic [IR_WIDTH-1:0]    rd_ir;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [NUM_CH-1:0]      rd_onehot;

    // Stage p0: shift each asynchronous strobe through its synchroniser; reset to 1 so a held strobe is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_p0 <= '1;
            udr_sync_p0 <= '1;
        end else begin
            uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
            udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
        end
    end

    assign uir_rise_p1 = uir_sync_p0[SYNC_STAGES-1] & ~uir_prev_p1;
    assign udr_rise_p1 = udr_sync_p0[SYNC_STAGES-1] & ~udr_prev_p1;

    // Stage p1: remember the previous synchronised level and latch the IR on an update-IR rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_prev_p1 <= 1'b1;
            udr_prev_p1 <= 1'b1;
            ir_latched  <= '0;
        end else begin
            uir_prev_p1 <= uir_sync_p0[SYNC_STAGES-1];
            udr_prev_p1 <= udr_sync_p0[SYNC_STAGES-1];
            if (uir_rise_p1) begin
                ir_latched <= ir_in;
            end
        end
    end

    // Full/empty from the extra pointer MSB; a full FIFO still accepts a push when it pops in the same cycle
    assign fifo_empty_w = (wr_ptr == rd_ptr);
    assign fifo_full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld_p1    = !fifo_empty_w && cmd_ready;
    assign push_vld_p1  = udr_rise_p1 && (!fifo_full_w || rd_vld_p1);
    assign drop_p1      = udr_rise_p1 && fifo_full_w && !rd_vld_p1;
    assign fifo_empty   = fifo_empty_w;

    assign rd_entry = fifo_mem[rd_ptr[AW-1:0]];
    assign rd_ir    = rd_entry[EW-1:DATA_WIDTH];
    assign rd_data  = rd_entry[DATA_WIDTH-1:0];

    // FIFO storage write; uses the pre-update ir_latched when both strobes rise together
    always_ff @(posedge clk) begin
        if (push_vld_p1) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {ir_latched, sr};
        end
    end

    // FIFO pointers and sticky overflow; a drop in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_vld_p1) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_vld_p1) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop_p1) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // One-hot channel select for the command at the FIFO head
    always_comb begin
        rd_onehot        = '0;
        rd_onehot[rd_ir] = 1'b1;
    end

    // Stage p2: register the dispatched command and raise exactly one single-cycle channel pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo            <= '0;
            cmd_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            if (rd_vld_p1) begin
                jdo    <= rd_data;
                cmd_ir <= rd_ir;
            end
            take_action    <= (rd_vld_p1 &&  rd_data[ACT_BIT]) ? rd_onehot : '0;
            take_no_action <= (rd_vld_p1 && !rd_data[ACT_BIT]) ? rd_onehot : '0;
        end
    end

`ifdef MOTION_DBG_CMD_COUNT_EN
    logic [15:0] cmd_count_q;

    // Count every dispatch; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_count_q <= '0;
        end else if (rd_vld_p1) begin
            cmd_count_q <= cmd_count_q + 16'd1;
        end
    end

    assign cmd_count = cmd_count_q;
`else
    assign cmd_count = 16'h0;
`endif

endmodule
